regfile_scoreboard: RTL and testbench

- Parametrised successor of the core integer register file.
- Configurable register count, data width and number of read ports.
- Optional write-to-read bypass, asynchronous clear of all architectural state, and a per-register pending (busy) scoreboard.
- Sits in the decode/execute boundary. Decode reads operands and busy flags; issue marks destinations pending; writeback writes data and clears pending.

---
 rtl/regfile_scoreboard.sv | 114 +++++++++++
 tb/tb_regfile_scoreboard.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- integer register file with a per-register pending
// (busy) scoreboard and optional write-to-read forwarding.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   write_enable/     writeback: stores write_data and clears the
//   write_address/      pending bit of write_address (x0 ignored)
//   write_data
//   issue_valid/      marks issue_address pending from the next cycle
//   issue_address
//   flush             synchronous clear of every pending bit
//   read_address      NUM_RD packed addresses, port i at [i*AW +: AW]
//   read_data         NUM_RD packed data words, port i at [i*XLEN +: XLEN]
//   read_busy         per-port pending flag
//   any_busy          OR of all stored pending bits (never forwarded)

// One combinational read port. Forwarding is gated by the caller so that a
// write qualified off (x0, reset) never reaches the read side.
module regfile_rd_port #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]               raddr,
  input  logic [NREGS-1:0][XLEN-1:0]  regs,
  input  logic [NREGS-1:0]            pend,
  input  logic                        wr_en,
  input  logic [AW-1:0]               waddr,
  input  logic [XLEN-1:0]             wdata,
  output logic [XLEN-1:0]             rdata,
  output logic                        rbusy
);
  localparam bit BYP = (BYPASS != 0);

  logic hit;

  assign hit   = BYP && wr_en && (waddr == raddr);
  // regs[0] and pend[0] are never set, so x0 reads as zero / not busy.
  assign rdata = hit ? wdata : regs[raddr];
  assign rbusy = hit ? 1'b0  : pend[raddr];
endmodule

module regfile_scoreboard #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NUM_RD = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write_enable,
  input  logic [AW-1:0]          write_address,
  input  logic [XLEN-1:0]        write_data,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_address,
  input  logic                   flush,
  input  logic [NUM_RD*AW-1:0]   read_address,
  output logic [NUM_RD*XLEN-1:0] read_data,
  output logic [NUM_RD-1:0]      read_busy,
  output logic                   any_busy
);
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           pend, pend_nxt;
  logic                       wr_en;
  logic                       fwd_en;

  assign wr_en  = write_enable && (write_address != '0);
  // While reset is held the read side must show zeros, so no forwarding.
  assign fwd_en = wr_en && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        regs <= '0;
    else if (wr_en) regs[write_address] <= write_data;
  end

  // Priority: flush > issue > writeback clear. Issue beats the clear
  // because the newly issued producer is the one the register now waits on.
  always_comb begin
    pend_nxt = pend;
    for (int r = 1; r < NREGS; r++) begin
      if (flush)
        pend_nxt[r] = 1'b0;
      else if (issue_valid && issue_address == AW'(r))
        pend_nxt[r] = 1'b1;
      else if (write_enable && write_address == AW'(r))
        pend_nxt[r] = 1'b0;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end

  assign any_busy = |pend;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_rd_port #(
      .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(BYPASS)
    ) u_rd (
      .raddr (read_address[g*AW +: AW]),
      .regs  (regs),
      .pend  (pend),
      .wr_en (fwd_en),
      .waddr (write_address),
      .wdata (write_data),
      .rdata (read_data[g*XLEN +: XLEN]),
      .rbusy (read_busy[g])
    );
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench: two builds driven from one stimulus stream.
//   dut_a: XLEN=32, NREGS=32, NUM_RD=2, BYPASS=1
//   dut_b: XLEN=64, NREGS=16, NUM_RD=3, BYPASS=0 (uses low 4 address bits)
// Reference model: plain arrays of register values and busy flags.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        we, iv, fl;
  logic [4:0]  wa, ia;
  logic [31:0] wd, hi;
  logic [4:0]  ra [3];

  logic [9:0]   ra_a;
  logic [63:0]  rd_a;
  logic [1:0]   rb_a;
  logic         ab_a;
  logic [11:0]  ra_b;
  logic [191:0] rd_b;
  logic [2:0]   rb_b;
  logic         ab_b;

  assign ra_a = {ra[1], ra[0]};
  assign ra_b = {ra[2][3:0], ra[1][3:0], ra[0][3:0]};

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst),
    .write_enable(we), .write_address(wa), .write_data(wd),
    .issue_valid(iv), .issue_address(ia), .flush(fl),
    .read_address(ra_a), .read_data(rd_a), .read_busy(rb_a), .any_busy(ab_a)
  );

  regfile_scoreboard #(.XLEN(64), .NREGS(16), .NUM_RD(3), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst),
    .write_enable(we), .write_address(wa[3:0]), .write_data({hi, wd}),
    .issue_valid(iv), .issue_address(ia[3:0]), .flush(fl),
    .read_address(ra_b), .read_data(rd_b), .read_busy(rb_b), .any_busy(ab_b)
  );

  // ---------------- reference model ----------------
  logic [31:0] ma [32];
  bit          pa [32];
  logic [63:0] mb [16];
  bit          pb [16];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  task automatic mclear();
    for (int i = 0; i < 32; i++) begin ma[i] = '0; pa[i] = 0; end
    for (int i = 0; i < 16; i++) begin mb[i] = '0; pb[i] = 0; end
  endtask

  // Apply one clock edge to the model using the inputs held that cycle.
  task automatic mstep();
    logic [3:0] wb, ib;
    wb = wa[3:0];
    ib = ia[3:0];
    if (rst) begin
      mclear();
      return;
    end
    if (we && wa != 0) ma[wa] = wd;
    if (we && wb != 0) mb[wb] = {hi, wd};
    if (fl) begin
      for (int i = 0; i < 32; i++) pa[i] = 0;
      for (int i = 0; i < 16; i++) pb[i] = 0;
    end else begin
      // clear first, then set: a same-cycle issue wins over the writeback
      if (we && wa != 0) pa[wa] = 0;
      if (we && wb != 0) pb[wb] = 0;
      if (iv && ia != 0) pa[ia] = 1;
      if (iv && ib != 0) pb[ib] = 1;
    end
  endtask

  task automatic check_all();
    logic [31:0] ed;
    logic [63:0] edb;
    logic        eb, any;
    logic [4:0]  a;
    logic [3:0]  b;
    for (int p = 0; p < 2; p++) begin
      a = ra[p];
      if (rst || a == 0)           begin ed = '0; eb = 0;     end
      else if (we && wa == a)      begin ed = wd; eb = 0;     end
      else                         begin ed = ma[a]; eb = pa[a]; end
      chk($sformatf("a_data%0d", p), 64'(rd_a[p*32 +: 32]), 64'(ed));
      chk($sformatf("a_busy%0d", p), 64'(rb_a[p]), 64'(eb));
    end
    any = 0;
    for (int i = 0; i < 32; i++) any |= pa[i];
    chk("a_any", 64'(ab_a), 64'(any && !rst));
    for (int p = 0; p < 3; p++) begin
      b = ra[p][3:0];
      if (rst || b == 0) begin edb = '0; eb = 0; end
      else               begin edb = mb[b]; eb = pb[b]; end
      chk($sformatf("b_data%0d", p), rd_b[p*64 +: 64], edb);
      chk($sformatf("b_busy%0d", p), 64'(rb_b[p]), 64'(eb));
    end
    any = 0;
    for (int i = 0; i < 16; i++) any |= pb[i];
    chk("b_any", 64'(ab_b), 64'(any && !rst));
  endtask

  // One cycle: drive at negedge, check combinational outputs, step the edge.
  task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [31:0] h, input logic i, input logic [4:0] ix,
                     input logic f, input logic [4:0] r0, input logic [4:0] r1,
                     input logic [4:0] r2);
    we = w; wa = a; wd = d; hi = h; iv = i; ia = ix; fl = f;
    ra[0] = r0; ra[1] = r1; ra[2] = r2;
    #2 check_all();
    @(posedge clk);
    mstep();
    @(negedge clk);
  endtask

  // Async reset in the middle of a cycle with a write/issue in flight,
  // held across one edge, released while the clock is low.
  task automatic do_reset(input logic [4:0] r);
    we = 1; wa = r; wd = $urandom; hi = $urandom; iv = 1; ia = r; fl = 0;
    ra[0] = r; ra[1] = r; ra[2] = r;
    #2 rst = 1;
    mclear();
    #1 check_all();
    @(posedge clk);
    mstep();
    #1 check_all();
    @(negedge clk);
    rst = 0;
  endtask

  function automatic logic [4:0] raddr();
    return ($urandom % 2 == 0) ? 5'($urandom % 8) : 5'($urandom % 32);
  endfunction

  initial begin
    we = 0; wa = 0; wd = 0; hi = 0; iv = 0; ia = 0; fl = 0;
    ra[0] = 0; ra[1] = 0; ra[2] = 0;
    rst = 1;
    mclear();
    @(negedge clk);
    ra[0] = 5; ra[1] = 9; ra[2] = 15;
    #1 check_all();
    rst = 0;
    @(negedge clk);

    // write x5, then an async reset wipes it immediately
    cyc(1, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 5, 0, 5);
    cyc(0, 0, 0, 0, 0, 0, 0, 5, 5, 5);
    do_reset(5);
    cyc(0, 0, 0, 0, 0, 0, 0, 5, 5, 5);
    // x0 write ignored
    cyc(1, 0, 32'h1234, 32'h1234, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // forwarding on port 1 (dut_a); dut_b sees the value a cycle later
    cyc(1, 7, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0, 0, 7, 7);
    cyc(0, 0, 0, 0, 0, 0, 0, 7, 7, 7);
    // scoreboard life cycle on x3
    cyc(0, 0, 0, 0, 1, 3, 0, 3, 3, 3);
    cyc(1, 3, 32'h55, 32'h0, 0, 0, 0, 3, 3, 3);
    cyc(0, 0, 0, 0, 0, 0, 0, 3, 3, 3);
    // issue/writeback collision on x9
    cyc(0, 0, 0, 0, 1, 9, 0, 9, 9, 9);
    cyc(1, 9, 32'h77, 32'h0, 1, 9, 0, 9, 9, 9);
    cyc(0, 0, 0, 0, 0, 0, 0, 9, 9, 9);
    // flush beats a same-cycle issue
    cyc(0, 0, 0, 0, 1, 1, 0, 1, 2, 4);
    cyc(0, 0, 0, 0, 1, 2, 0, 1, 2, 4);
    cyc(0, 0, 0, 0, 1, 4, 0, 1, 2, 4);
    cyc(0, 0, 0, 0, 1, 6, 1, 1, 2, 6);
    cyc(0, 0, 0, 0, 0, 0, 0, 4, 6, 9);
    // wide build, top register, all ports and one x0 port
    cyc(1, 15, 32'hFFFF0000, 32'hFFFF0000, 0, 0, 0, 15, 15, 15);
    cyc(0, 0, 0, 0, 0, 0, 0, 15, 15, 15);
    cyc(0, 0, 0, 0, 0, 0, 0, 15, 15, 0);

    // randomized traffic with collisions biased into low registers
    for (int n = 0; n < 600; n++) begin
      if ($urandom % 64 == 0) do_reset(raddr());
      else cyc(1'($urandom % 2), raddr(), $urandom, $urandom,
               1'($urandom % 2), raddr(), 1'($urandom % 20 == 0),
               raddr(), raddr(), raddr());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
